// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO port arbiter: read-side FSM states
// and the usable-capacity helper (one slot stays empty in the FIFO).
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_POP,
    R_HOLD
  } rd_state_e;

  function automatic int cap_of(input int logsize);
    return (1 << logsize) - 1;
  endfunction

endpackage

// File: rtl/fifo_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from req,
// ports clk/resetn, req in, gnt/any/win out; pointer moves past winner.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            any,
  output logic [PW-1:0]   win
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx_p;
  int            idx;

  // Scan from the pointer; first requester found wins.
  always_comb begin
    any   = 1'b0;
    win   = '0;
    idx   = 0;
    idx_p = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_p = PW'(idx);
      if (!any && req[idx_p]) begin
        any = 1'b1;
        win = idx_p;
      end
    end
    gnt = '0;
    if (any) gnt[win] = 1'b1;
    ptr_d = ptr_q;
    if (any) begin
      ptr_d = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fifo_port_arbiter.sv
// Shares one FIFO among NREQ producers (rr + credit admission) and
// turns its rd-pulse pop protocol into a valid/ready stream.
module fifo_port_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int LOGSIZE = 2,
  parameter int SIZE    = 1 << LOGSIZE
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  fifo_wr,
  output logic [WIDTH-1:0]      fifo_din,
  output logic                  fifo_rd,
  input  logic [WIDTH-1:0]      fifo_dout,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [LOGSIZE-1:0]    occupancy
);

  localparam int CAP = cap_of(LOGSIZE);
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    gnt;
  logic               any;
  logic [PW-1:0]      win;
  logic               free;
  logic               inc;
  logic               dec;

  logic [NREQ-1:0]    ack_q, ack_d;
  logic               wr_q, wr_d;
  logic [WIDTH-1:0]   din_q, din_d;
  logic               rd_q, rd_d;
  logic               valid_q, valid_d;
  logic [LOGSIZE-1:0] occ_q, occ_d;
  rd_state_e          st_q, st_d;

  // Pops in this cycle are not credited back to admission.
  assign free = (int'(occ_q) < CAP);
  assign elig = req & {NREQ{free}};

  rr_arbiter #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_rr (
    .clk   (clk),
    .resetn(resetn),
    .req   (elig),
    .gnt   (gnt),
    .any   (any),
    .win   (win)
  );

  always_comb begin
    inc   = any;
    dec   = (st_q == R_POP);
    ack_d = gnt;
    wr_d  = any;
    din_d = din_q;
    if (any) din_d = req_data[int'(win)*WIDTH +: WIDTH];

    occ_d = occ_q;
    if (inc && !dec)      occ_d = occ_q + 1'b1;
    else if (!inc && dec) occ_d = occ_q - 1'b1;

    // fifo_empty only gates: occupancy may lead the FIFO by one
    // cycle while the committed word is still on fifo_wr.
    st_d = st_q;
    unique case (st_q)
      R_IDLE: begin
        if (occ_q != '0 && !fifo_empty) st_d = R_POP;
      end
      R_POP: st_d = R_HOLD;
      R_HOLD: begin
        if (out_ready) begin
          if (occ_d != '0 && !fifo_empty) st_d = R_POP;
          else                            st_d = R_IDLE;
        end
      end
      default: st_d = R_IDLE;
    endcase
    rd_d    = (st_d == R_POP);
    valid_d = (st_d == R_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ack_q   <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      occ_q   <= '0;
      st_q    <= R_IDLE;
    end else begin
      ack_q   <= ack_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
      st_q    <= st_d;
    end
  end

  assign ack       = ack_q;
  assign fifo_wr   = wr_q;
  assign fifo_din  = din_q;
  assign fifo_rd   = rd_q;
  assign out_valid = valid_q;
  // FIFO output register only moves on a pop, so this is stable in R_HOLD.
  assign out_data  = valid_q ? fifo_dout : '0;
  assign occupancy = occ_q;

  a_no_overflow : assert property (
    @(posedge clk) disable iff (!resetn)
    !(inc && !dec && occ_q == LOGSIZE'(SIZE - 1)));

  a_no_underflow : assert property (
    @(posedge clk) disable iff (!resetn)
    !(dec && !inc && occ_q == '0));

  a_empty_lag : assert property (
    @(posedge clk) disable iff (!resetn)
    (occ_q != '0 && fifo_empty) |=> !(occ_q != '0 && fifo_empty));

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Bench for fifo_port_arbiter: behavioural FIFO, scoreboard model,
// directed scenarios then randomized traffic with occasional resets.
module tb_fifo_port_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int LOGSIZE = 2;
  localparam int CAP     = (1 << LOGSIZE) - 1;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  fifo_wr;
  logic [WIDTH-1:0]      fifo_din;
  logic                  fifo_rd;
  logic [WIDTH-1:0]      fifo_dout;
  logic                  fifo_empty;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [LOGSIZE-1:0]    occupancy;

  always #5 clk = ~clk;

  fifo_port_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .LOGSIZE(LOGSIZE)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .fifo_rd   (fifo_rd),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  // 4-entry FIFO: one pop per rd assertion, rd must drop to re-arm.
  logic [WIDTH-1:0] mem [4];
  logic [1:0]       wp, rp;
  logic             armed;
  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (!resetn) begin
      wp <= '0; rp <= '0; armed <= 1'b1; fifo_dout <= '0;
    end else begin
      if (fifo_wr) begin
        mem[wp] <= fifo_din;
        wp <= wp + 2'd1;
      end
      if (fifo_rd && armed && !fifo_empty) begin
        fifo_dout <= mem[rp];
        rp <= rp + 2'd1;
      end
      armed <= !fifo_rd;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  int               m_ptr = 0;
  int               m_occ = 0;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] deliv[$];
  int               acks[$];
  logic [NREQ-1:0]  exp_ack = '0;
  logic             exp_wr = 1'b0;
  logic [WIDTH-1:0] exp_din = '0;
  logic             held = 1'b0;
  logic [WIDTH-1:0] held_data = '0;
  logic             post_rst = 1'b0;
  int               hold_cycles = 0;

  // Predict what the coming posedge does, from current inputs/outputs.
  task automatic model_edge();
    int w;
    logic [NREQ-1:0] elig;
    if (!resetn) begin
      m_occ = 0; m_ptr = 0; sb.delete();
      held = 1'b0; exp_ack = '0; exp_wr = 1'b0;
      post_rst = 1'b1;
      return;
    end
    post_rst = 1'b0;
    if (fifo_rd) check("rd_with_data", 64'(m_occ > 0), 64'(1));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        check("out_data", 64'(out_data), 64'(sb[0]));
        deliv.push_back(out_data);
        void'(sb.pop_front());
      end
      held = 1'b0;
    end else if (out_valid) begin
      held = 1'b1;
      held_data = out_data;
    end else begin
      held = 1'b0;
    end
    elig = (m_occ < CAP) ? req : '0;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && elig[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    end
    exp_ack = '0;
    exp_wr  = 1'b0;
    if (w >= 0) begin
      exp_ack[w] = 1'b1;
      exp_wr  = 1'b1;
      exp_din = req_data[w*WIDTH +: WIDTH];
      sb.push_back(exp_din);
      acks.push_back(w);
      m_ptr = (w + 1) % NREQ;
      m_occ++;
    end
    if (fifo_rd) m_occ--;
  endtask

  task automatic check_outputs();
    check("ack", 64'(ack), 64'(exp_ack));
    check("fifo_wr", 64'(fifo_wr), 64'(exp_wr));
    if (exp_wr) check("fifo_din", 64'(fifo_din), 64'(exp_din));
    check("occupancy", 64'(occupancy), 64'(m_occ));
    check("rd_excl", 64'(fifo_rd & out_valid), 64'(0));
    if (held) begin
      hold_cycles++;
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_data", 64'(out_data), 64'(held_data));
      check("hold_rd", 64'(fifo_rd), 64'(0));
    end
    if (post_rst) begin
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_data", 64'(out_data), 64'(0));
      check("rst_rd", 64'(fifo_rd), 64'(0));
    end
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req = '0;
    step();
    step();
    resetn = 1'b1;
    acks.delete();
    deliv.delete();
  endtask

  task automatic drain(input int n_words, input string tag);
    int t;
    t = 0;
    req = '0;
    out_ready = 1'b1;
    while (deliv.size() < n_words && t < 60) begin
      step();
      t++;
    end
    check(tag, 64'(deliv.size()), 64'(n_words));
  endtask

  initial begin
    int acnt;
    int n;
    logic [WIDTH-1:0] d0;
    resetn = 1'b0; req = '0; req_data = '0; out_ready = 1'b0;

    // Reset then idle.
    do_reset();
    for (int i = 0; i < 10; i++) step();
    check("idle_valid", 64'(out_valid), 64'(0));

    // Single producer word on port 2.
    out_ready = 1'b1;
    req = 4'b0100;
    req_data[2*WIDTH +: WIDTH] = 32'hA5A5_0001;
    step();
    check("single_ack", 64'(ack), 64'(4'b0100));
    drain(1, "single_timeout");
    if (deliv.size() > 0) check("single_data", 64'(deliv[0]), 64'h0A5A5_0001);
    step();
    check("single_occ0", 64'(occupancy), 64'(0));

    // Round-robin fairness from a fresh pointer.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      req_data[i*WIDTH +: WIDTH] = WIDTH'(32'h10 + i);
    out_ready = 1'b1;
    req = '1;
    for (int i = 0; i < 20; i++) step();
    n = acks.size();
    check("rr_progress", 64'(n >= 8), 64'(1));
    for (int k = 0; k < n; k++) check("rr_order", 64'(acks[k]), 64'(k % NREQ));
    drain(n, "rr_timeout");
    for (int k = 0; k < deliv.size(); k++)
      check("rr_data", 64'(deliv[k]), 64'(32'h10 + (k % NREQ)));

    // Back-pressure: one word parked at the output plus CAP in the FIFO.
    do_reset();
    out_ready = 1'b0;
    req = 4'b0001;
    d0 = '0;
    req_data[0 +: WIDTH] = d0;
    acnt = 0;
    hold_cycles = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (ack[0]) begin
        acnt++;
        d0 = d0 + 1;
        req_data[0 +: WIDTH] = d0;
      end
    end
    check("bp_acks", 64'(acnt), 64'(CAP + 1));
    check("bp_occ", 64'(occupancy), 64'(CAP));
    check("bp_wr", 64'(fifo_wr), 64'(0));
    check("bp_valid", 64'(out_valid), 64'(1));
    check("bp_held", 64'(hold_cycles >= 5), 64'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack[0]) begin
        acnt++;
        d0 = d0 + 1;
        req_data[0 +: WIDTH] = d0;
      end
    end
    check("bp_resume", 64'(acnt > CAP + 1), 64'(1));
    for (int k = 0; k < 4 && k < deliv.size(); k++)
      check("bp_order", 64'(deliv[k]), 64'(k));

    // Reset in the middle of a transfer.
    do_reset();
    out_ready = 1'b0;
    req = 4'b0001;
    req_data[0 +: WIDTH] = 32'h1111_0000;
    step(); step(); step();
    req = '0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check("mid_valid", 64'(out_valid), 64'(1));
    check("mid_occ", 64'(occupancy), 64'(2));
    resetn = 1'b0;
    step();
    check("mid_rst_occ", 64'(occupancy), 64'(0));
    check("mid_rst_ack", 64'(ack), 64'(0));
    check("mid_rst_wr", 64'(fifo_wr), 64'(0));
    check("mid_rst_din", 64'(fifo_din), 64'(0));
    resetn = 1'b1;
    deliv.delete();
    req = 4'b0001;
    req_data[0 +: WIDTH] = 32'hDEAD_0000;
    step();
    drain(1, "mid_timeout");
    if (deliv.size() > 0) check("mid_data", 64'(deliv[0]), 64'h0DEAD_0000);

    // Random traffic with rare resets.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      req = NREQ'($urandom);
      for (int p = 0; p < NREQ; p++) req_data[p*WIDTH +: WIDTH] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      resetn = ($urandom_range(0, 99) != 0);
      step();
    end
    resetn = 1'b1;
    n = 0;
    req = '0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      step();
      n++;
    end
    check("rand_drain", 64'(sb.size()), 64'(0));
    check("rand_occ", 64'(occupancy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
